// File: rtl/tx_link_arbiter.sv
// Round-robin arbiter sharing the 2-bit serial TX link between up to four requesters.
// Optional TX_LINK_PARITY_EN appends a {0,P} parity symbol after the payload.
module tx_link_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_W     = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [1:0]                tx_pins,
    output logic                      busy,
    output logic [1:0]                grant_id
);
    localparam int PAIRS = DATA_W / 2;
    localparam int CNT_W = $clog2(PAIRS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAIRS - 1);
    localparam logic [3:0]       GAP_LAST = 4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE, START, HDR, SHIFT, GAP
`ifdef TX_LINK_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t            state, state_d;
    logic [1:0]        tx_d, gid_d, ptr, ptr_d, win_id;
    logic              busy_d, win_found;
    logic [DATA_W-1:0] sh, sh_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [3:0]        gap_cnt, gap_d;
    logic [3:0]        valid4, ready4;
    logic [DATA_W-1:0] words [4];
`ifdef TX_LINK_PARITY_EN
    logic              par, par_d;
`endif

    // Pad requesters out to four slots so the winner index is always a clean 2-bit select.
    assign valid4 = 4'(req_valid);
    always_comb begin
        for (int i = 0; i < 4; i++) words[i] = '0;
        for (int i = 0; i < NUM_REQ; i++) words[i] = req_data[i*DATA_W +: DATA_W];
    end

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!win_found && valid4[2'((int'(ptr) + off) % NUM_REQ)]) begin
                win_found = 1'b1;
                win_id    = 2'((int'(ptr) + off) % NUM_REQ);
            end
        end
    end

    assign ready4    = (state == IDLE && win_found) ? (4'b0001 << win_id) : 4'b0000;
    assign req_ready = ready4[NUM_REQ-1:0];

    always_comb begin
        state_d = state;
        tx_d    = tx_pins;
        busy_d  = busy;
        gid_d   = grant_id;
        ptr_d   = ptr;
        sh_d    = sh;
        cnt_d   = cnt;
        gap_d   = gap_cnt;
`ifdef TX_LINK_PARITY_EN
        par_d   = par;
`endif
        case (state)
            IDLE: begin
                tx_d   = 2'b00;
                busy_d = 1'b0;
                if (win_found) begin
                    state_d = START;
                    tx_d    = 2'b01;
                    busy_d  = 1'b1;
                    gid_d   = win_id;
                    ptr_d   = win_id;
                    sh_d    = words[win_id];
`ifdef TX_LINK_PARITY_EN
                    par_d   = ^{win_id, words[win_id]};
`endif
                end
            end
            START: begin
                tx_d    = grant_id;
                state_d = HDR;
            end
            HDR: begin
                tx_d    = sh[1:0];
                sh_d    = sh >> 2;
                cnt_d   = CNT_LAST;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt != '0) begin
                    tx_d  = sh[1:0];
                    sh_d  = sh >> 2;
                    cnt_d = cnt - 1'b1;
                end else begin
`ifdef TX_LINK_PARITY_EN
                    tx_d    = {1'b0, par};
                    state_d = PARITY;
`else
                    tx_d = 2'b00;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_LAST;
                    end
`endif
                end
            end
`ifdef TX_LINK_PARITY_EN
            PARITY: begin
                tx_d = 2'b00;
                if (GAP_CYCLES == 0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = GAP;
                    gap_d   = GAP_LAST;
                end
            end
`endif
            GAP: begin
                tx_d = 2'b00;
                if (gap_cnt == 4'd0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_cnt - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 2'b00;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_pins  <= 2'b00;
            busy     <= 1'b0;
            grant_id <= 2'b00;
            ptr      <= 2'(NUM_REQ - 1);
            sh       <= '0;
            cnt      <= '0;
            gap_cnt  <= '0;
`ifdef TX_LINK_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            tx_pins  <= tx_d;
            busy     <= busy_d;
            grant_id <= gid_d;
            ptr      <= ptr_d;
            sh       <= sh_d;
            cnt      <= cnt_d;
            gap_cnt  <= gap_d;
`ifdef TX_LINK_PARITY_EN
            par      <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_tx_link_arbiter.sv
// Randomized bench for tx_link_arbiter against a symbol-queue reference model.
module tb_tx_link_arbiter;
    localparam int NUM_REQ    = 3;
    localparam int DATA_W     = 16;
    localparam int GAP_CYCLES = 1;
`ifdef TX_LINK_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = 3 + DATA_W/2 + GAP_CYCLES + PAR;
    localparam int NG_FRAME = 3 + DATA_W/2 + PAR;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [1:0]                tx_pins, grant_id;
    logic                      busy;

    logic [NUM_REQ-1:0]        ng_valid = 3'b001;
    logic [NUM_REQ*DATA_W-1:0] ng_data  = 48'h0000_0000_1234;
    logic [NUM_REQ-1:0]        ng_ready;
    logic [1:0]                ng_tx, ng_grant;
    logic                      ng_busy;

    always #5 clk = ~clk;

    tx_link_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_pins(tx_pins), .busy(busy), .grant_id(grant_id));

    tx_link_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .GAP_CYCLES(0)) u_nogap (
        .clk(clk), .rst_n(rst_n), .req_valid(ng_valid), .req_data(ng_data),
        .req_ready(ng_ready), .tx_pins(ng_tx), .busy(ng_busy), .grant_id(ng_grant));

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model: pending link symbols, last-granted pointer, current grant.
    logic [1:0] q[$];
    logic [1:0] sym_log[$];
    int m_ptr, m_grant;
    int rdy_cyc[$], rdy_id[$], ng_acc[$];
    bit seen2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic reset_model();
        q.delete();
        m_ptr   = NUM_REQ - 1;
        m_grant = 0;
    endtask

    // Called at posedge+1: check registered outputs, drive inputs, check req_ready, advance.
    task automatic step(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*DATA_W-1:0] d);
        bit cur_busy;
        logic [1:0] cur_sym;
        logic [3:0] v4;
        logic [DATA_W-1:0] w;
        logic [NUM_REQ-1:0] exp_rdy;
        int win, ones;
        cur_busy = (q.size() > 0);
        cur_sym  = cur_busy ? q.pop_front() : 2'b00;
        chk("tx", 32'(tx_pins), 32'(cur_sym));
        chk("busy", 32'(busy), 32'(cur_busy));
        chk("grant", 32'(grant_id), 32'(m_grant));
        sym_log.push_back(tx_pins);
        req_valid = v;
        req_data  = d;
        #1;
        v4 = 4'(v);
        win = -1;
        if (!cur_busy)
            for (int k = 1; k <= NUM_REQ; k++)
                if (win < 0 && v4[2'((m_ptr + k) % NUM_REQ)]) win = (m_ptr + k) % NUM_REQ;
        exp_rdy = (win >= 0) ? NUM_REQ'(1 << win) : '0;
        chk("ready", 32'(req_ready), 32'(exp_rdy));
        if (req_ready != '0) begin
            rdy_cyc.push_back(cyc);
            rdy_id.push_back(req_ready[0] ? 0 : req_ready[1] ? 1 : 2);
        end
        if (req_ready[2]) seen2 = 1'b1;
        if (ng_ready[0]) ng_acc.push_back(cyc);
        if (win >= 0) begin
            w = DATA_W'(d >> (win * DATA_W));
            m_ptr = win;
            m_grant = win;
            q.push_back(2'b01);
            q.push_back(2'(win));
            for (int j = 0; j < DATA_W/2; j++) q.push_back(2'(w >> (2*j)));
            ones = $countones(w) + $countones(2'(win));
            if (PAR == 1) q.push_back({1'b0, 1'(ones % 2)});
            repeat (GAP_CYCLES) q.push_back(2'b00);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [NUM_REQ*DATA_W-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [1:0] exp_sf[$];
        reset_model();
        #12;
        chk("rst_tx", 32'(tx_pins), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_ready", 32'(req_ready), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single frame from requester 1 carrying A5C3.
        exp_sf = '{2'd1, 2'd1, 2'd3, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2};
        if (PAR == 1) exp_sf.push_back(2'd1);
        exp_sf.push_back(2'd0);
        sym_log.delete();
        step(3'b010, {16'h1111, 16'hA5C3, 16'h2222});
        repeat (exp_sf.size() + 1) step('0, rnd_data());
        foreach (exp_sf[i]) chk("sf_sym", 32'(sym_log[i+1]), 32'(exp_sf[i]));

        // Reset in the middle of SHIFT, checked before any clock edge.
        step(3'b100, rnd_data());
        repeat (5) step('0, rnd_data());
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(tx_pins), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_grant", 32'(grant_id), 0);
        reset_model();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round robin with all requesters valid.
        rdy_cyc.delete();
        rdy_id.delete();
        repeat (5 * FRAME + 2) step(3'b111, rnd_data());
        chk("rr_count", 32'(rdy_id.size() >= 5), 1);
        if (rdy_id.size() >= 5) begin
            chk("rr_id0", 32'(rdy_id[0]), 0);
            chk("rr_id1", 32'(rdy_id[1]), 1);
            chk("rr_id2", 32'(rdy_id[2]), 2);
            chk("rr_id3", 32'(rdy_id[3]), 0);
            chk("rr_id4", 32'(rdy_id[4]), 1);
            for (int i = 1; i < 5; i++) chk("rr_spacing", 32'(rdy_cyc[i] - rdy_cyc[i-1]), FRAME);
        end

        // Withdrawal: requester 2 valid for a single busy cycle only.
        repeat (FRAME) step('0, rnd_data());
        step(3'b001, rnd_data());
        seen2 = 1'b0;
        step(3'b100, rnd_data());
        repeat (2 * FRAME) step('0, rnd_data());
        chk("wd_ready2", 32'(seen2), 0);

        // Random traffic with mixed request densities.
        for (int n = 0; n < 1500; n++) begin
            logic [NUM_REQ-1:0] v;
            v = NUM_REQ'($urandom);
            if (n % 200 < 100) v = v & NUM_REQ'($urandom);
            step(v, rnd_data());
        end

        // Back-to-back frames on the zero-gap instance.
        ng_acc.delete();
        repeat (4 * NG_FRAME) step('0, rnd_data());
        chk("ng_count", 32'(ng_acc.size() >= 3), 1);
        if (ng_acc.size() >= 3)
            for (int i = 1; i < 3; i++) chk("ng_spacing", 32'(ng_acc[i] - ng_acc[i-1]), NG_FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
